// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU engine: opcodes, FSM state
// codes and flag bit positions.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // flags = {ovf, carry, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/seq_alu_fsm.sv
// Controller for the sequential ALU: IDLE -> LOAD_A -> LOAD_B -> EXEC -> DONE.
// Optional feature macro: SEQ_ALU_CHAIN_EN (chain=1 at start skips LOAD_A and
// reuses the previous result as operand A).
// Handshake: start is looked at only in IDLE; a start seen there is accepted
// on that edge (accept_o high for that cycle). done_o is high for exactly the
// one DONE cycle. start while busy_o=1 is dropped, nothing is queued.
module seq_alu_fsm
  import seq_alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       chain_i,
  output logic [2:0] state_o,
  output logic       busy_o,
  output logic       accept_o,
  output logic       ld_a_o,
  output logic       ld_b_o,
  output logic       ld_chain_o,
  output logic       exec_o,
  output logic       done_o
);

  state_e state_q, state_d;

`ifndef SEQ_ALU_CHAIN_EN
  // Chaining is compiled out; the port stays for a stable interface.
  logic unused_chain;
  assign unused_chain = chain_i;
`endif

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-state strobes; illegal codes fall back to IDLE.
  always_comb begin
    state_d    = state_q;
    accept_o   = 1'b0;
    ld_a_o     = 1'b0;
    ld_b_o     = 1'b0;
    ld_chain_o = 1'b0;
    exec_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept_o = 1'b1;
          state_d  = ST_LOAD_A;
`ifdef SEQ_ALU_CHAIN_EN
          if (chain_i) begin
            state_d    = ST_LOAD_B;
            ld_chain_o = 1'b1;
          end
`endif
        end
      end
      ST_LOAD_A: begin
        ld_a_o  = 1'b1;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        ld_b_o  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_o  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/seq_alu_engine.sv
// Multi-cycle WIDTH-bit ALU: serial operand load on data_in, 8 opcodes,
// registered result and {ovf, carry, zero} flags, start/done handshake.
// Optional feature macro: SEQ_ALU_CHAIN_EN (see seq_alu_fsm).
module seq_alu_engine
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_in,
  input  logic             chain,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic [2:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept, ld_a, ld_b, ld_chain, exec;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] reg_a_q, reg_b_q, data_out_q;
  logic [2:0]       flags_q;
  logic [WIDTH-1:0] res_d;
  logic [2:0]       flags_d;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [SHW-1:0]   shamt;

  seq_alu_fsm u_fsm (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .chain_i    (chain),
    .state_o    (state),
    .busy_o     (busy),
    .accept_o   (accept),
    .ld_a_o     (ld_a),
    .ld_b_o     (ld_b),
    .ld_chain_o (ld_chain),
    .exec_o     (exec),
    .done_o     (done)
  );

  // Opcode capture with an accepted start; operand loads under FSM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      if (accept)        op_q    <= op_in;
      if (ld_a)          reg_a_q <= data_in;
      else if (ld_chain) reg_a_q <= data_out_q;
      if (ld_b)          reg_b_q <= data_in;
    end
  end

  assign sum_w  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
  assign diff_w = {1'b0, reg_a_q} - {1'b0, reg_b_q};
  assign shamt  = reg_b_q[SHW-1:0];

  // ALU function and flags; carry/ovf only meaningful for ADD and SUB.
  always_comb begin
    res_d   = reg_a_q;
    flags_d = 3'b000;
    case (op_q)
      OP_ADD: begin
        res_d               = sum_w[WIDTH-1:0];
        flags_d[FLAG_CARRY] = sum_w[WIDTH];
        flags_d[FLAG_OVF]   = (reg_a_q[WIDTH-1] == reg_b_q[WIDTH-1]) &&
                              (sum_w[WIDTH-1] != reg_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d               = diff_w[WIDTH-1:0];
        flags_d[FLAG_CARRY] = diff_w[WIDTH];  // borrow: A < B unsigned
        flags_d[FLAG_OVF]   = (reg_a_q[WIDTH-1] != reg_b_q[WIDTH-1]) &&
                              (diff_w[WIDTH-1] != reg_a_q[WIDTH-1]);
      end
      OP_AND:  res_d = reg_a_q & reg_b_q;
      OP_OR:   res_d = reg_a_q | reg_b_q;
      OP_XOR:  res_d = reg_a_q ^ reg_b_q;
      OP_SHL:  res_d = reg_a_q << shamt;
      OP_SHR:  res_d = reg_a_q >> shamt;
      default: res_d = reg_a_q;
    endcase
    flags_d[FLAG_ZERO] = (res_d == '0);
  end

  // Result and flags update only in EXEC and hold until the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      flags_q    <= 3'b000;
    end else if (exec) begin
      data_out_q <= res_d;
      flags_q    <= flags_d;
    end
  end

  assign data_out = data_out_q;
  assign flags    = flags_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;

endmodule
